// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit and receive paths: one-hot FSM
// encoding, parity selectors, frame width and the parity helper.
package uart_pkg;

    typedef enum logic [4:0] {
        INTERVAL  = 5'b00001,
        STARTBIT  = 5'b00010,
        DATABITS  = 5'b00100,
        PARITYBIT = 5'b01000,
        STOPBIT   = 5'b10000
    } uart_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;
    localparam int   DATA_BITS   = 8;

    // Even parity makes the total count of ones even, odd parity makes it odd.
    function automatic logic parity_of(input logic [7:0] b, input logic method);
        return (method == PARITY_ODD) ? ~^b : ^b;
    endfunction

endpackage

// File: rtl/uart_tx_core_if.sv
// FIFO write-side register bus of the UART transmitter: host writes/clears,
// core reports fill status.
interface uart_tx_core_if;

    logic [7:0]  data_i;
    logic        n_we_i;
    logic        n_clr_i;
    logic        p_full_o;
    logic        p_empty_o;
    logic [15:0] bytes_in_fifo_o;

    modport master (
        output data_i, n_we_i, n_clr_i,
        input  p_full_o, p_empty_o, bytes_in_fifo_o
    );

    modport slave (
        input  data_i, n_we_i, n_clr_i,
        output p_full_o, p_empty_o, bytes_in_fifo_o
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with active-low write/read/clear strobes and registered
// full/empty/count; read data is the head entry, valid whenever not empty.
module uart_tx_fifo #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        data,
    input  logic              n_we,
    input  logic              n_re,
    input  logic              n_clr,
    output logic [7:0]        rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_nxt;
    logic              do_wr;
    logic              do_rd;

    // Clear wins over a same-cycle write or pop.
    assign do_wr   = !n_we && !full  && n_clr;
    assign do_rd   = !n_re && !empty && n_clr;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        // NOTE: default assignment first so no path leaves count_nxt unassigned (no latch).
        count_nxt = count;
        if (!n_clr)
            count_nxt = '0;
        else if (do_wr && !do_rd)
            count_nxt = count + (ADDR_W + 1)'(1);
        else if (do_rd && !do_wr)
            count_nxt = count - (ADDR_W + 1)'(1);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (!n_clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_wr) wr_ptr <= wr_ptr + ADDR_W'(1);
                if (do_rd) rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
            empty <= (count_nxt == '0);
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= data;
    end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: FIFO-fed serialiser emitting start, 8 data bits, optional
// parity and stop bit, one bit per BaudSig_i period.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_core_if.slave     bus,
    input  logic              BaudSig_i,
    input  logic              p_ParityEnable_i,
    input  logic              p_BigEnd_i,
    input  logic              ParityMethod_i,
    output logic              p_Busy_o,
    output logic              p_DataSent_o,
    output logic [4:0]        State_o,
    output logic              Tx_o
);

    uart_state_e     state;
    logic [7:0]      shreg;
    logic [3:0]      bit_cnt;
    logic            par_en;
    logic            big_end;
    logic            par_bit;

    logic [7:0]      fifo_data;
    logic            fifo_empty;
    logic [ADDR_W:0] fifo_count;
    logic            pop;
    logic            next_bit;
    logic [7:0]      shreg_shifted;

    uart_tx_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .data    (bus.data_i),
        .n_we    (bus.n_we_i),
        .n_re    (~pop),
        .n_clr   (bus.n_clr_i),
        .rd_data (fifo_data),
        .full    (bus.p_full_o),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bus.p_empty_o       = fifo_empty;
    assign bus.bytes_in_fifo_o = 16'(fifo_count);
    assign State_o             = state;

    // A byte is fetched when idle or as a stop bit ends, giving back-to-back frames.
    assign pop           = BaudSig_i && !fifo_empty && (state == INTERVAL || state == STOPBIT);
    assign next_bit      = big_end ? shreg[7] : shreg[0];
    assign shreg_shifted = big_end ? {shreg[6:0], 1'b0} : {1'b0, shreg[7:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= INTERVAL;
            Tx_o         <= 1'b1;
            p_Busy_o     <= 1'b0;
            p_DataSent_o <= 1'b0;
            shreg        <= '0;
            bit_cnt      <= '0;
            par_en       <= 1'b0;
            big_end      <= 1'b0;
            par_bit      <= 1'b0;
        end else begin
            p_DataSent_o <= BaudSig_i && (state == STOPBIT);
            if (pop) begin
                // Configuration is frozen per frame at the moment the byte is fetched.
                shreg    <= fifo_data;
                par_en   <= p_ParityEnable_i;
                big_end  <= p_BigEnd_i;
                par_bit  <= parity_of(fifo_data, ParityMethod_i);
                state    <= STARTBIT;
                Tx_o     <= 1'b0;
                p_Busy_o <= 1'b1;
            end else if (BaudSig_i) begin
                unique case (state)
                    INTERVAL: begin
                        Tx_o     <= 1'b1;
                        p_Busy_o <= 1'b0;
                    end
                    STARTBIT: begin
                        Tx_o    <= next_bit;
                        shreg   <= shreg_shifted;
                        bit_cnt <= 4'd1;
                        state   <= DATABITS;
                    end
                    DATABITS: begin
                        if (bit_cnt == 4'(DATA_BITS)) begin
                            state <= par_en ? PARITYBIT : STOPBIT;
                            Tx_o  <= par_en ? par_bit : 1'b1;
                        end else begin
                            Tx_o    <= next_bit;
                            shreg   <= shreg_shifted;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    PARITYBIT: begin
                        Tx_o  <= 1'b1;
                        state <= STOPBIT;
                    end
                    STOPBIT: begin
                        Tx_o     <= 1'b1;
                        p_Busy_o <= 1'b0;
                        state    <= INTERVAL;
                    end
                    default: begin
                        Tx_o     <= 1'b1;
                        p_Busy_o <= 1'b0;
                        state    <= INTERVAL;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Scoreboard bench for uart_tx_core: stimulus queues hand-computed frame bits,
// a monitor compares Tx_o at every bit boundary while the core is busy.
module tb_uart_tx_core;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       BaudSig_i;
    logic       p_ParityEnable_i;
    logic       p_BigEnd_i;
    logic       ParityMethod_i;
    logic       p_Busy_o;
    logic       p_DataSent_o;
    logic [4:0] State_o;
    logic       Tx_o;

    uart_tx_core_if bus();

    uart_tx_core #(.DEPTH(128), .ADDR_W(7)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .BaudSig_i        (BaudSig_i),
        .p_ParityEnable_i (p_ParityEnable_i),
        .p_BigEnd_i       (p_BigEnd_i),
        .ParityMethod_i   (ParityMethod_i),
        .p_Busy_o         (p_Busy_o),
        .p_DataSent_o     (p_DataSent_o),
        .State_o          (State_o),
        .Tx_o             (Tx_o)
    );

    always #5 clk = ~clk;

    int   n_cmp    = 0;
    int   n_err    = 0;
    int   sent_cnt = 0;
    int   sent_exp = 0;
    int   cyc      = 0;
    int   baud_div = 0;
    bit   baud_en  = 1'b0;
    bit   mon_en   = 1'b1;
    logic baud_at_edge = 1'b0;
    logic last_tx  = 1'b1;
    logic exp_bit;
    logic exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Lowest n bits of seq, most significant first, are the bits in send order.
    task automatic push_frame(input logic [10:0] seq, input int n);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(seq[i]);
        sent_exp++;
    endtask

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        bus.data_i = b;
        bus.n_we_i = 1'b0;
        @(negedge clk);
        bus.n_we_i = 1'b1;
    endtask

    task automatic sync_baud();
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!BaudSig_i && n < 64);
    endtask

    task automatic wait_busy(input logic lvl, input int max, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (p_Busy_o !== lvl && cycles < max);
        check("wait_busy", p_Busy_o, lvl);
    endtask

    task automatic wait_sent(input int max);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (p_DataSent_o !== 1'b1 && n < max);
        check("wait_sent", p_DataSent_o, 1'b1);
    endtask

    always @(posedge clk) begin
        cyc          <= cyc + 1;
        baud_at_edge <= BaudSig_i;
    end

    initial begin
        BaudSig_i = 1'b0;
        forever begin
            @(negedge clk);
            baud_div  = (baud_div == 15) ? 0 : baud_div + 1;
            BaudSig_i = baud_en && (baud_div == 0);
        end
    end

    // Monitor: a new bit appears on the edge that sampled BaudSig_i; between
    // those edges Tx_o must hold.
    initial begin
        forever begin
            @(negedge clk);
            if (p_DataSent_o === 1'b1) sent_cnt++;
            if (mon_en && !rst && p_Busy_o === 1'b1) begin
                if (baud_at_edge) begin
                    if (exp_q.size() == 0) begin
                        check("tx_extra_bit", p_Busy_o, 1'b0);
                    end else begin
                        exp_bit = exp_q.pop_front();
                        check("tx_bit", Tx_o, exp_bit);
                    end
                end else begin
                    check("tx_hold", Tx_o, last_tx);
                end
            end
            last_tx = Tx_o;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int t0;
        int s0;
        rst              = 1'b1;
        bus.data_i       = 8'h00;
        bus.n_we_i       = 1'b1;
        bus.n_clr_i      = 1'b1;
        p_ParityEnable_i = 1'b0;
        p_BigEnd_i       = 1'b0;
        ParityMethod_i   = PARITY_EVEN;
        repeat (3) @(negedge clk);
        check("rst_tx",    Tx_o, 1'b1);
        check("rst_state", State_o, INTERVAL);
        check("rst_busy",  p_Busy_o, 1'b0);
        check("rst_sent",  p_DataSent_o, 1'b0);
        check("rst_empty", bus.p_empty_o, 1'b1);
        check("rst_full",  bus.p_full_o, 1'b0);
        check("rst_count", bus.bytes_in_fifo_o, 16'd0);
        rst     = 1'b0;
        baud_en = 1'b1;

        // 1: 0xA5, no parity, LSB first
        push_frame(11'b0_0101001011, 10);
        write_byte(8'hA5);
        wait_busy(1'b1, 40, c);
        wait_busy(1'b0, 400, c);
        check("t1_frame_clks", c, 160);
        check("t1_empty", bus.p_empty_o, 1'b1);
        check("t1_count", bus.bytes_in_fifo_o, 16'd0);
        check("t1_bits_left", exp_q.size(), 0);
        check("t1_sent", sent_cnt, sent_exp);

        // 2: 0x03 with parity: even, odd, then odd MSB first
        p_ParityEnable_i = 1'b1;
        push_frame(11'b0_11000000_0_1, 11);
        write_byte(8'h03);
        wait_busy(1'b1, 40, c);
        ParityMethod_i = PARITY_ODD;
        wait_busy(1'b0, 400, c);
        check("t2_even_clks", c, 176);
        push_frame(11'b0_11000000_1_1, 11);
        write_byte(8'h03);
        wait_busy(1'b1, 40, c);
        wait_busy(1'b0, 400, c);
        check("t2_odd_clks", c, 176);
        p_BigEnd_i = 1'b1;
        push_frame(11'b0_00000011_1_1, 11);
        write_byte(8'h03);
        wait_busy(1'b1, 40, c);
        wait_busy(1'b0, 400, c);
        check("t2_bigend_clks", c, 176);
        check("t2_bits_left", exp_q.size(), 0);
        check("t2_sent", sent_cnt, sent_exp);
        p_ParityEnable_i = 1'b0;
        p_BigEnd_i       = 1'b0;
        ParityMethod_i   = PARITY_EVEN;

        // 3: three back-to-back frames
        push_frame(11'b0_0100010001, 10);
        push_frame(11'b0_0010001001, 10);
        push_frame(11'b0_0110011001, 10);
        sync_baud();
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        check("t3_count3", bus.bytes_in_fifo_o, 16'd3);
        wait_busy(1'b1, 40, c);
        t0 = cyc;
        check("t3_count2", bus.bytes_in_fifo_o, 16'd2);
        wait_sent(400);
        check("t3_count1", bus.bytes_in_fifo_o, 16'd1);
        wait_sent(400);
        check("t3_count0", bus.bytes_in_fifo_o, 16'd0);
        wait_sent(400);
        check("t3_span_clks", cyc - t0, 480);
        check("t3_idle", p_Busy_o, 1'b0);
        check("t3_bits_left", exp_q.size(), 0);
        check("t3_sent", sent_cnt, sent_exp);

        // 4: fill with BaudSig held low
        baud_en = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 127; i++) write_byte(8'(i));
        check("t4_count127", bus.bytes_in_fifo_o, 16'd127);
        check("t4_notfull", bus.p_full_o, 1'b0);
        write_byte(8'h7F);
        check("t4_full", bus.p_full_o, 1'b1);
        check("t4_count128", bus.bytes_in_fifo_o, 16'd128);
        write_byte(8'hEE);
        check("t4_drop_count", bus.bytes_in_fifo_o, 16'd128);
        check("t4_drop_full", bus.p_full_o, 1'b1);
        check("t4_drop_empty", bus.p_empty_o, 1'b0);
        @(negedge clk);
        bus.n_clr_i = 1'b0;
        @(negedge clk);
        bus.n_clr_i = 1'b1;
        check("t4_clr_count", bus.bytes_in_fifo_o, 16'd0);
        check("t4_clr_empty", bus.p_empty_o, 1'b1);
        check("t4_clr_full", bus.p_full_o, 1'b0);
        baud_en = 1'b1;

        // 5: clear mid-frame with five bytes queued
        push_frame(11'b0_0010110101, 10);
        sync_baud();
        write_byte(8'h5A);
        for (int i = 1; i <= 5; i++) write_byte(8'(i));
        wait_busy(1'b1, 40, c);
        check("t5_queued", bus.bytes_in_fifo_o, 16'd5);
        repeat (4) sync_baud();
        @(negedge clk);
        bus.n_clr_i = 1'b0;
        @(negedge clk);
        bus.n_clr_i = 1'b1;
        check("t5_clr_count", bus.bytes_in_fifo_o, 16'd0);
        check("t5_still_busy", p_Busy_o, 1'b1);
        wait_busy(1'b0, 400, c);
        repeat (48) @(negedge clk);
        check("t5_idle_tx", Tx_o, 1'b1);
        check("t5_idle_state", State_o, INTERVAL);
        check("t5_bits_left", exp_q.size(), 0);
        check("t5_sent", sent_cnt, sent_exp);

        // 6: reset during DATABITS
        mon_en = 1'b0;
        sync_baud();
        write_byte(8'hC3);
        write_byte(8'h7E);
        wait_busy(1'b1, 40, c);
        c = 0;
        while (State_o !== DATABITS && c < 64) begin
            @(negedge clk);
            c++;
        end
        check("t6_in_databits", State_o, DATABITS);
        repeat (2) sync_baud();
        @(negedge clk);
        rst = 1'b1;
        s0  = sent_cnt;
        @(negedge clk);
        check("t6_rst_tx", Tx_o, 1'b1);
        check("t6_rst_state", State_o, INTERVAL);
        check("t6_rst_empty", bus.p_empty_o, 1'b1);
        check("t6_rst_count", bus.bytes_in_fifo_o, 16'd0);
        check("t6_rst_busy", p_Busy_o, 1'b0);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check("t6_no_sent", sent_cnt, s0);
        check("t6_idle_tx", Tx_o, 1'b1);
        check("t6_idle_state", State_o, INTERVAL);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
